// File: rtl/vs_sci_pkg.sv
// Shared SCI definitions for the VS10xx serial control interface.
// Holds SCI opcodes, SCI register addresses, the SCI writer state
// type and a helper that assembles a 32-bit SCI write frame.
package vs_sci_pkg;

  localparam logic [7:0] SCI_OP_WRITE = 8'h02;
  localparam logic [7:0] SCI_OP_READ  = 8'h03;

  localparam logic [7:0] SCI_MODE = 8'h00;
  localparam logic [7:0] SCI_VOL  = 8'h0B;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    SHIFT,
    HOLD,
    GUARD
  } sci_state_t;

  // Frame layout on the wire, MSB first: opcode, address, data[15:8], data[7:0].
  function automatic logic [31:0] sci_write_frame(input logic [7:0]  addr,
                                                  input logic [15:0] data);
    return {SCI_OP_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/sci_clk_gen.sv
// SPI half-period strobe generator.
// Counts 0..HALF_DIV-1 while enabled and alternates between a low and
// a high half-period; emits sclk_rise at the end of each low half and
// sclk_fall at the end of each high half. Disabling clears the counter
// so every enable starts with a full low half-period.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         run the counter (held low outside a shift phase)
//   sclk_rise  one-cycle strobe: sclk should go high on this edge
//   sclk_fall  one-cycle strobe: sclk should go low on this edge
module sci_clk_gen
  import vs_sci_pkg::*;
#(
  parameter int unsigned HALF_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;   // 0: low half-period, 1: high half-period
  logic          term;

  always_comb begin
    term      = (cnt == CW'(HALF_DIV - 1));
    sclk_rise = en && term && !phase;
    sclk_fall = en && term && phase;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (term) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vs_sci_vol_writer.sv
// Writes the volume attenuation word to the VS10xx SCI_VOL register.
// Any change of vol against the last written value (shadow) marks a
// write pending; the block then requests the shared SPI bus, waits for
// grant and DREQ together, and shifts one 32-bit SCI write frame.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   vol       attenuation word (0x0000 loudest, 0xFFFF mute)
//   dreq      VS10xx DREQ, sampled only before a frame starts
//   bus_gnt   SPI bus grant from the pin mux
//   bus_req   SPI bus request
//   xcs       SCI chip select, active low
//   sclk      SPI clock, idle low
//   si        SPI data to the chip
//   busy      high whenever the writer is not idle
//   done      one-cycle pulse as a frame completes
module vs_sci_vol_writer
  import vs_sci_pkg::*;
#(
  parameter int unsigned HALF_DIV  = 50,
  parameter int unsigned GUARD_CYC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] vol,
  input  logic        dreq,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic        xcs,
  output logic        sclk,
  output logic        si,
  output logic        busy,
  output logic        done
);

  sci_state_t  state;
  logic [15:0] shadow;
  logic        pending;
  logic [31:0] sreg;
  logic [4:0]  bit_cnt;
  logic [15:0] wait_cnt;
  logic [31:0] frame_w;
  logic        vol_changed;
  logic        sclk_rise;
  logic        sclk_fall;

  always_comb begin
    frame_w     = sci_write_frame(SCI_VOL, vol);
    vol_changed = (vol != shadow);
  end

  sci_clk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state == SHIFT),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= 16'hFFFF;
      pending  <= 1'b1;
      sreg     <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      bus_req  <= 1'b0;
      xcs      <= 1'b1;
      sclk     <= 1'b0;
      si       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (vol_changed) pending <= 1'b1;

      case (state)
        IDLE: begin
          // A change seen this cycle starts the request without waiting
          // for pending to register.
          if (pending || vol_changed) begin
            bus_req <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end

        REQ: begin
          if (bus_gnt && dreq) begin
            sreg     <= frame_w;
            si       <= frame_w[31];
            shadow   <= vol;
            pending  <= 1'b0;   // overrides the change-detect set above
            xcs      <= 1'b0;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (wait_cnt == 16'(HALF_DIV - 1)) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        SHIFT: begin
          if (sclk_rise) sclk <= 1'b1;
          if (sclk_fall) begin
            sclk <= 1'b0;
            si   <= sreg[30];
            sreg <= {sreg[30:0], 1'b0};
            if (bit_cnt == 5'd31) begin
              wait_cnt <= '0;
              state    <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        HOLD: begin
          if (wait_cnt == 16'(HALF_DIV - 1)) begin
            xcs      <= 1'b1;
            done     <= 1'b1;
            wait_cnt <= '0;
            state    <= GUARD;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        GUARD: begin
          if (wait_cnt == 16'(GUARD_CYC - 1)) begin
            bus_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
